pipe_elastic: RTL and testbench
===============================

# pipe_elastic

Parametrised elastic register pipeline on the DTI valid/ready interface, successor to the fixed `dreg` chain. It inserts `LENGTH` full-throughput register stages between a consumer and a producer port. Each stage is either a pass-through-ready register or a decoupled skid stage with registered `ready`. The block reports live occupancy and optionally supports a synchronous flush. It sits on long routes and timing-critical handshakes between gears, wherever a plain register chain would leave a combinational `ready` path or drop throughput.

## Interface
Parameters:
- `LENGTH`, 2: number of stages; 0 selects combinational bypass.
- `DIN`, 16: data width of `din`/`dout`.
- `DECOUPLE`, 0: 0 selects a single-entry stage with a combinational `ready` path; 1 selects a two-entry skid stage with registered `ready`.
- `OCC_W`, derived: `$clog2(LENGTH*(DECOUPLE+1)+1)`, minimum 1.

Ports:
- `clk`  in  1  sole clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  dti.consumer  `DIN`  upstream data/valid/ready.
- `dout`  dti.producer  `DIN`  downstream data/valid/ready.
- `occupancy`  out  `OCC_W`  items currently held.
- `flush`  in  1  synchronous clear; present only with `PIPE_ELASTIC_FLUSH_EN`.

## Operation
- A transfer occurs on an edge where `valid && ready` on that port.
- Stage k's input is stage k-1's output; stage 0 takes `din`; stage `LENGTH-1` drives `dout`.
- Items are never dropped, duplicated or reordered.
- **DECOUPLE=0 stage:**
  - Registers `v` and `d`.
  - `ready_in = !v || ready_out`, combinational.
  - Loads on an input transfer.
  - Clears `v` on an output transfer with no simultaneous input.
- **DECOUPLE=1 stage:**
  - Registers main `(mv, md)`, skid `(sv, sd)` and `rdy`.
  - `ready_in = rdy`, registered.
  - Stage states: EMPTY (!mv), ONE (mv, !sv), FULL (mv, sv).
  - Transitions:
    - EMPTY + in -> ONE.
    - ONE + in + out -> ONE.
    - ONE + in + !out -> FULL; the new item goes to skid.
    - ONE + out -> EMPTY.
    - FULL + out -> ONE; skid moves to main.
  - `rdy` is 1 exactly when the next state is not FULL.
- **LENGTH=0:**
  - `dout.data = din.data`, `dout.valid = din.valid`, `din.ready = dout.ready`.
  - `occupancy` is constant 0.
  - `flush` is ignored.
- **Occupancy:**
  - Registered counter: +1 on a `din` transfer, -1 on a `dout` transfer, unchanged when both occur.
  - Never exceeds `LENGTH*(DECOUPLE+1)` and never wraps.
- **Flush** (when compiled in):
  - In a cycle with `flush`=1, `din.ready` and `dout.valid` are forced to 0, so no transfer occurs.
  - At that edge all `v`/`mv`/`sv` clear, `occupancy` becomes 0 and `rdy` becomes 1.
  - Data registers are not cleared.

## Timing
- Reset values:
  - All valid bits 0.
  - All data registers 0.
  - `rdy` 1.
  - `occupancy` 0.
  - `dout.valid` 0.
  - `dout.data` 0.
  - `din.ready` 1 (both modes, `LENGTH` > 0).
- Reset asserted mid-operation discards all held items immediately (asynchronous); the first accept is possible on the first edge after deassertion.
- Latency: an item accepted at edge t appears on `dout.valid` after edge t+`LENGTH-1`, i.e. `LENGTH` cycles after `din.valid`, with no back-pressure.
- Throughput: one item per cycle in both modes while `dout.ready`=1.
- Back-pressure capacity before `din.ready` falls:
  - `LENGTH` items in DECOUPLE=0.
  - `2*LENGTH` items in DECOUPLE=1.
- DECOUPLE=1: no combinational path from `dout.ready` to `din.ready`. `din.ready` changes one cycle after downstream stalls or releases.
- `occupancy` reflects transfers one edge after they occur.

## Configuration
- Macro: `PIPE_ELASTIC_FLUSH_EN`.
- Defined: the `flush` port exists and behaves as in Operation.
- Undefined: no `flush` port and no flush logic; behaviour is identical to `flush` tied to 0.

## Structure
- Shared package `pipe_elastic_pkg`:
  - `occ_width(length, decouple)` function.
  - `pipe_stage_mode_e` enum: `STAGE_REG`=0, `STAGE_SKID`=1.
  - Stage state encoding `skid_state_e`: EMPTY, ONE, FULL.
- Sub-module `pipe_elastic_stage`:
  - One stage, selected by the `DECOUPLE` parameter.
  - Has the `clk`/`rst`/(`flush`) inputs.
  - Instantiated `LENGTH` times in a generate loop.
- The top level holds the generate chain, the `LENGTH`=0 bypass and the occupancy counter.

## Test plan
- Reset, then LENGTH=3, DECOUPLE=0: stream 0x01..0x08 with `dout.ready`=1 -> `dout` emits 0x01..0x08 in order; first valid 3 cycles after first `din.valid`; one item per cycle; `occupancy` steady at 3.
- LENGTH=2, DECOUPLE=1: hold `dout.ready`=0 while offering 0xA0..0xA5 -> exactly 4 accepted, `din.ready`=0, `occupancy`=4. Release -> 0xA0..0xA5 delivered in order with no gaps.
- DECOUPLE=1: toggle `dout.ready` every cycle with continuous input -> `din.ready` never depends combinationally on `dout.ready` in the same cycle; no loss or duplication over 100 random items.
- LENGTH=0: `din.valid`=1, `din.data`=0x55, `dout.ready`=0 -> `dout.valid`=1, `dout.data`=0x55, `din.ready`=0 in the same cycle; `occupancy`=0.
- `PIPE_ELASTIC_FLUSH_EN`, LENGTH=4, DECOUPLE=1 with 5 items held: pulse `flush` -> no transfer that cycle; next cycle `occupancy`=0, `dout.valid`=0, `din.ready`=1.
- Assert `rst` asynchronously mid-stream with `occupancy`=3 -> all valids and `occupancy` go to 0 before the next edge; the stream restarts cleanly after deassertion.

Source files
------------

// File: rtl/pipe_elastic_pkg.sv
// pipe_elastic_pkg: shared types and helpers for the pipe_elastic block.
// Optional feature macro used by the block: PIPE_ELASTIC_FLUSH_EN.
package pipe_elastic_pkg;

  typedef enum logic {
    STAGE_REG  = 1'b0,
    STAGE_SKID = 1'b1
  } pipe_stage_mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Occupancy counter width: enough to hold LENGTH*(DECOUPLE+1), at least 1 bit.
  function automatic int unsigned occ_width(input int unsigned length,
                                            input int unsigned decouple);
    int unsigned max_occ;
    int unsigned w;
    max_occ = length * (decouple + 1);
    w = $clog2(max_occ + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipe_elastic_if.sv
// pipe_elastic_if: DTI valid/ready handshake bundle.
// producer/master drives data+valid, consumer/slave drives ready.
interface pipe_elastic_if #(
  parameter int unsigned DIN = 16
);
  logic [DIN-1:0] data;
  logic           valid;
  logic           ready;

  modport producer (output data, output valid, input  ready);
  modport consumer (input  data, input  valid, output ready);
  modport master   (output data, output valid, input  ready);
  modport slave    (input  data, input  valid, output ready);
endinterface

// File: rtl/pipe_elastic_stage.sv
// pipe_elastic_stage: one elastic register stage.
// DECOUPLE=0: single entry, combinational ready. DECOUPLE=1: two-entry skid
// stage with registered ready. flush_i exists only with PIPE_ELASTIC_FLUSH_EN.
module pipe_elastic_stage
  import pipe_elastic_pkg::*;
#(
  parameter int unsigned DIN      = 16,
  parameter int unsigned DECOUPLE = 0
) (
  input  logic           clk,
  input  logic           rst,
`ifdef PIPE_ELASTIC_FLUSH_EN
  input  logic           flush_i,
`endif
  input  logic           in_valid_i,
  input  logic [DIN-1:0] in_data_i,
  output logic           in_ready_o,
  output logic           out_valid_o,
  output logic [DIN-1:0] out_data_o,
  input  logic           out_ready_i
);

  localparam pipe_stage_mode_e MODE = (DECOUPLE != 0) ? STAGE_SKID : STAGE_REG;

  logic clr;
`ifdef PIPE_ELASTIC_FLUSH_EN
  assign clr = flush_i;
`else
  assign clr = 1'b0;
`endif

  if (MODE == STAGE_REG) begin : g_reg
    logic           v_q;
    logic [DIN-1:0] d_q;

    assign in_ready_o  = !v_q || out_ready_i;
    assign out_valid_o = v_q;
    assign out_data_o  = d_q;

    // Load on input transfer; drop valid when the held item leaves alone.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (clr) begin
        v_q <= 1'b0;
      end else if (in_valid_i && in_ready_o) begin
        v_q <= 1'b1;
        d_q <= in_data_i;
      end else if (out_ready_i) begin
        v_q <= 1'b0;
      end
    end
  end else begin : g_skid
    skid_state_e    state_q;
    logic [DIN-1:0] md_q;
    logic [DIN-1:0] sd_q;
    logic           rdy_q;
    logic           in_xfer;
    logic           out_xfer;

    assign in_xfer     = in_valid_i && rdy_q;
    assign out_xfer    = (state_q != EMPTY) && out_ready_i;
    assign in_ready_o  = rdy_q;
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = md_q;

    // Main/skid occupancy FSM; rdy_q is set to (next state != FULL).
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= EMPTY;
        md_q    <= '0;
        sd_q    <= '0;
        rdy_q   <= 1'b1;
      end else if (clr) begin
        state_q <= EMPTY;
        rdy_q   <= 1'b1;
      end else begin
        case (state_q)
          EMPTY: begin
            if (in_xfer) begin
              state_q <= ONE;
              md_q    <= in_data_i;
            end
          end
          ONE: begin
            if (in_xfer && out_xfer) begin
              md_q <= in_data_i;
            end else if (in_xfer) begin
              state_q <= FULL;
              sd_q    <= in_data_i;
              rdy_q   <= 1'b0;
            end else if (out_xfer) begin
              state_q <= EMPTY;
            end
          end
          FULL: begin
            if (out_xfer) begin
              state_q <= ONE;
              md_q    <= sd_q;
              rdy_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pipe_elastic.sv
// pipe_elastic: LENGTH-stage elastic pipeline on the DTI valid/ready handshake
// with a live occupancy counter. LENGTH=0 is a combinational bypass.
// Optional synchronous flush port enabled by PIPE_ELASTIC_FLUSH_EN.
module pipe_elastic
  import pipe_elastic_pkg::*;
#(
  parameter  int unsigned LENGTH   = 2,
  parameter  int unsigned DIN      = 16,
  parameter  int unsigned DECOUPLE = 0,
  localparam int unsigned OCC_W    = occ_width(LENGTH, DECOUPLE)
) (
  input  logic             clk,
  input  logic             rst,
  pipe_elastic_if.consumer din,
  pipe_elastic_if.producer dout,
  output logic [OCC_W-1:0] occupancy
`ifdef PIPE_ELASTIC_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  if (LENGTH == 0) begin : g_bypass
    assign dout.data  = din.data;
    assign dout.valid = din.valid;
    assign din.ready  = dout.ready;
    assign occupancy  = '0;
  end else begin : g_chain
    logic flush_w;
`ifdef PIPE_ELASTIC_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    logic [LENGTH:0] c_valid;
    logic [LENGTH:0] c_ready;
    logic [DIN-1:0]  c_data [LENGTH+1];
    logic            in_xfer;
    logic            out_xfer;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Flush blocks both external handshakes so nothing transfers that cycle.
    assign c_valid[0]      = din.valid && !flush_w;
    assign c_data[0]       = din.data;
    assign din.ready       = c_ready[0] && !flush_w;
    assign c_ready[LENGTH] = dout.ready && !flush_w;
    assign dout.valid      = c_valid[LENGTH] && !flush_w;
    assign dout.data       = c_data[LENGTH];

    for (genvar k = 0; k < LENGTH; k++) begin : g_stage
      pipe_elastic_stage #(
        .DIN      (DIN),
        .DECOUPLE (DECOUPLE)
      ) u_stage (
        .clk         (clk),
        .rst         (rst),
`ifdef PIPE_ELASTIC_FLUSH_EN
        .flush_i     (flush_w),
`endif
        .in_valid_i  (c_valid[k]),
        .in_data_i   (c_data[k]),
        .in_ready_o  (c_ready[k]),
        .out_valid_o (c_valid[k+1]),
        .out_data_o  (c_data[k+1]),
        .out_ready_i (c_ready[k+1])
      );
    end

    assign in_xfer  = c_valid[0] && c_ready[0];
    assign out_xfer = c_valid[LENGTH] && c_ready[LENGTH];

    // Next occupancy: +1 on accept, -1 on emit, cleared by flush.
    always_comb begin
      occ_d = occ_q;
      if (flush_w) begin
        occ_d = '0;
      end else if (in_xfer && !out_xfer) begin
        occ_d = occ_q + 1'b1;
      end else if (out_xfer && !in_xfer) begin
        occ_d = occ_q - 1'b1;
      end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        occ_q <= '0;
      end else begin
        occ_q <= occ_d;
      end
    end

    assign occupancy = occ_q;
  end

endmodule

// File: tb/tb_pipe_elastic.sv
// tb_pipe_elastic: self-checking bench for pipe_elastic.
// Four instances: A (LENGTH=3, DECOUPLE=0), B (2,1), C (0,0), D (4,1).
// The flush sequence is compiled only with PIPE_ELASTIC_FLUSH_EN.
module tb_pipe_elastic;

  logic clk;
  logic rst;
  logic no_flush;
  logic flush_d;

  int n_checks;
  int n_fail;

  pipe_elastic_if #(.DIN(8)) a_in ();
  pipe_elastic_if #(.DIN(8)) a_out ();
  pipe_elastic_if #(.DIN(8)) b_in ();
  pipe_elastic_if #(.DIN(8)) b_out ();
  pipe_elastic_if #(.DIN(8)) c_in ();
  pipe_elastic_if #(.DIN(8)) c_out ();
  pipe_elastic_if #(.DIN(8)) d_in ();
  pipe_elastic_if #(.DIN(8)) d_out ();

  logic [1:0] a_occ;
  logic [2:0] b_occ;
  logic [0:0] c_occ;
  logic [3:0] d_occ;

  pipe_elastic #(.LENGTH(3), .DIN(8), .DECOUPLE(0)) u_a (
    .clk(clk), .rst(rst), .din(a_in), .dout(a_out), .occupancy(a_occ)
`ifdef PIPE_ELASTIC_FLUSH_EN
    , .flush(no_flush)
`endif
  );
  pipe_elastic #(.LENGTH(2), .DIN(8), .DECOUPLE(1)) u_b (
    .clk(clk), .rst(rst), .din(b_in), .dout(b_out), .occupancy(b_occ)
`ifdef PIPE_ELASTIC_FLUSH_EN
    , .flush(no_flush)
`endif
  );
  pipe_elastic #(.LENGTH(0), .DIN(8), .DECOUPLE(0)) u_c (
    .clk(clk), .rst(rst), .din(c_in), .dout(c_out), .occupancy(c_occ)
`ifdef PIPE_ELASTIC_FLUSH_EN
    , .flush(no_flush)
`endif
  );
  pipe_elastic #(.LENGTH(4), .DIN(8), .DECOUPLE(1)) u_d (
    .clk(clk), .rst(rst), .din(d_in), .dout(d_out), .occupancy(d_occ)
`ifdef PIPE_ELASTIC_FLUSH_EN
    , .flush(flush_d)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: push on accept, pop and compare on emit (sampled mid-cycle).
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qd[$];
  logic [7:0] ea, eb, ed;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_in.valid && a_in.ready) qa.push_back(a_in.data);
      if (a_out.valid && a_out.ready) begin
        check("a_sb_nonempty", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          check("a_sb_data", 32'(a_out.data), 32'(ea));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (b_in.valid && b_in.ready) qb.push_back(b_in.data);
      if (b_out.valid && b_out.ready) begin
        check("b_sb_nonempty", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          check("b_sb_data", 32'(b_out.data), 32'(eb));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (d_in.valid && d_in.ready) qd.push_back(d_in.data);
      if (d_out.valid && d_out.ready) begin
        check("d_sb_nonempty", 32'(qd.size() != 0), 32'd1);
        if (qd.size() != 0) begin
          ed = qd.pop_front();
          check("d_sb_data", 32'(d_out.data), 32'(ed));
        end
      end
    end
  end

  int  b_idx;
  logic b_ov;
  int  d_idx;

  // One cycle on B: note whether the offered item is taken, advance on accept.
  task automatic b_cycle(input int limit);
    logic acc;
    @(negedge clk);
    acc  = b_in.valid && b_in.ready;
    b_ov = b_out.valid;
    @(posedge clk);
    #1;
    if (acc) begin
      b_idx++;
      if (b_idx < limit) b_in.data = 8'(8'hA0 + b_idx);
      else b_in.valid = 1'b0;
    end
  endtask

  task automatic d_cycle(input int limit);
    logic acc;
    @(negedge clk);
    acc = d_in.valid && d_in.ready;
    @(posedge clk);
    #1;
    if (acc) begin
      d_idx++;
      if (d_idx < limit) d_in.data = 8'(8'h10 + d_idx);
      else d_in.valid = 1'b0;
    end
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       ev;
    logic [7:0] ed;
    logic       er;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int   acc_n;
    int   out_n;
    int   sent;
    logic r1, r2, acc;

    n_checks = 0;
    n_fail   = 0;
    tbl[0] = '{1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0};
    tbl[1] = '{1'b1, 8'hAA, 1'b1, 1'b1, 8'hAA, 1'b1};
    tbl[2] = '{1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1};

    rst = 1'b1; no_flush = 1'b0; flush_d = 1'b0;
    a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
    b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;
    c_in.valid = 1'b0; c_in.data = '0; c_out.ready = 1'b0;
    d_in.valid = 1'b0; d_in.data = '0; d_out.ready = 1'b0;
    repeat (2) step();

    // Reset values
    check("a_rst_dout_valid", 32'(a_out.valid), 32'd0);
    check("a_rst_din_ready",  32'(a_in.ready),  32'd1);
    check("a_rst_occ",        32'(a_occ),       32'd0);
    check("b_rst_dout_valid", 32'(b_out.valid), 32'd0);
    check("b_rst_dout_data",  32'(b_out.data),  32'd0);
    check("b_rst_din_ready",  32'(b_in.ready),  32'd1);
    check("b_rst_occ",        32'(b_occ),       32'd0);
    check("d_rst_din_ready",  32'(d_in.ready),  32'd1);
    rst = 1'b0;

    // A: stream 0x01..0x08 with dout.ready held high
    a_out.ready = 1'b1;
    a_in.valid  = 1'b1;
    a_in.data   = 8'h01;
    for (int k = 1; k <= 11; k++) begin
      step();
      acc_n = (k < 8) ? k : 8;
      out_n = (k <= 3) ? 0 : ((k - 3 > 8) ? 8 : k - 3);
      check("a_stream_valid", 32'(a_out.valid), 32'(k >= 3 && k <= 10));
      check("a_stream_occ",   32'(a_occ),       32'(acc_n - out_n));
      check("a_stream_ready", 32'(a_in.ready),  32'd1);
      if (k < 8) a_in.data = 8'(k + 1);
      else a_in.valid = 1'b0;
    end
    check("a_stream_drained", 32'(qa.size()), 32'd0);

    // B: back-pressure, then release with gapless delivery
    b_idx = 0;
    b_out.ready = 1'b0;
    b_in.valid  = 1'b1;
    b_in.data   = 8'hA0;
    for (int k = 0; k < 8; k++) b_cycle(6);
    check("b_bp_accepted", 32'(b_idx),      32'd4);
    check("b_bp_din_ready", 32'(b_in.ready), 32'd0);
    check("b_bp_occ",      32'(b_occ),      32'd4);
    b_out.ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b_cycle(6);
      check("b_release_nogap", 32'(b_ov), 32'(k < 6));
    end
    check("b_release_all", 32'(b_idx), 32'd6);
    check("b_release_occ", 32'(b_occ), 32'd0);
    check("b_release_sb",  32'(qb.size()), 32'd0);

    // B: toggling dout.ready; din.ready must not follow it within a cycle
    sent = 0;
    b_in.valid = 1'b1;
    b_in.data  = 8'($urandom);
    for (int cyc = 0; cyc < 1000 && sent < 100; cyc++) begin
      b_out.ready = ((cyc % 2) == 1);
      #1 r1 = b_in.ready;
      b_out.ready = ~b_out.ready;
      #1 r2 = b_in.ready;
      b_out.ready = ~b_out.ready;
      check("b_ready_indep", 32'(r2), 32'(r1));
      @(negedge clk);
      acc = b_in.valid && b_in.ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        if (sent < 100) b_in.data = 8'($urandom);
        else b_in.valid = 1'b0;
      end
    end
    check("b_toggle_sent", 32'(sent), 32'd100);
    b_in.valid  = 1'b0;
    b_out.ready = 1'b1;
    repeat (8) step();
    check("b_toggle_sb",  32'(qb.size()), 32'd0);
    check("b_toggle_occ", 32'(b_occ),     32'd0);

    // C: LENGTH=0 combinational bypass table
    for (int i = 0; i < 5; i++) begin
      c_in.valid  = tbl[i].v;
      c_in.data   = tbl[i].d;
      c_out.ready = tbl[i].r;
      #1;
      check("c_dout_valid", 32'(c_out.valid), 32'(tbl[i].ev));
      check("c_dout_data",  32'(c_out.data),  32'(tbl[i].ed));
      check("c_din_ready",  32'(c_in.ready),  32'(tbl[i].er));
      check("c_occ",        32'(c_occ),       32'd0);
      step();
    end

    // D: DECOUPLE=1 capacity of 2*LENGTH
    d_idx = 0;
    d_out.ready = 1'b0;
    d_in.valid  = 1'b1;
    d_in.data   = 8'h10;
    for (int k = 0; k < 12; k++) d_cycle(20);
    check("d_cap_accepted", 32'(d_idx),      32'd8);
    check("d_cap_din_ready", 32'(d_in.ready), 32'd0);
    check("d_cap_occ",      32'(d_occ),      32'd8);
    d_in.valid  = 1'b0;
    d_out.ready = 1'b1;
    repeat (12) step();
    check("d_cap_drain_occ", 32'(d_occ),     32'd0);
    check("d_cap_drain_sb",  32'(qd.size()), 32'd0);

`ifdef PIPE_ELASTIC_FLUSH_EN
    // D: flush with 5 items held
    d_idx = 0;
    d_out.ready = 1'b0;
    d_in.valid  = 1'b1;
    d_in.data   = 8'h10;
    for (int k = 0; k < 10 && d_idx < 5; k++) d_cycle(5);
    check("d_fl_held", 32'(d_occ), 32'd5);
    d_in.valid = 1'b1;
    d_in.data  = 8'hEE;
    d_out.ready = 1'b1;
    flush_d = 1'b1;
    #1;
    check("d_fl_din_ready_blocked", 32'(d_in.ready),  32'd0);
    check("d_fl_dout_valid_blocked", 32'(d_out.valid), 32'd0);
    step();
    flush_d    = 1'b0;
    d_in.valid = 1'b0;
    qd.delete();
    check("d_fl_occ",        32'(d_occ),       32'd0);
    check("d_fl_dout_valid", 32'(d_out.valid), 32'd0);
    check("d_fl_din_ready",  32'(d_in.ready),  32'd1);
    d_idx = 0;
    d_in.valid = 1'b1;
    d_in.data  = 8'h10;
    for (int k = 0; k < 10 && d_idx < 3; k++) d_cycle(3);
    repeat (10) step();
    check("d_fl_restart_sb",  32'(qd.size()), 32'd0);
    check("d_fl_restart_occ", 32'(d_occ),     32'd0);
`endif

    // A: asynchronous reset mid-stream at occupancy 3
    a_out.ready = 1'b1;
    a_in.valid  = 1'b1;
    a_in.data   = 8'h30;
    for (int k = 0; k < 3; k++) begin
      step();
      a_in.data = 8'(8'h31 + k);
    end
    check("a_mid_occ", 32'(a_occ), 32'd3);
    #1 rst = 1'b1;
    #1;
    check("a_arst_dout_valid", 32'(a_out.valid), 32'd0);
    check("a_arst_occ",        32'(a_occ),       32'd0);
    qa.delete();
    qb.delete();
    qd.delete();
    a_in.data = 8'h40;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) check("a_restart_first_accept", 32'(a_occ), 32'd1);
      if (k < 3) a_in.data = 8'(8'h41 + k);
      else a_in.valid = 1'b0;
    end
    repeat (5) step();
    check("a_restart_sb",  32'(qa.size()), 32'd0);
    check("a_restart_occ", 32'(a_occ),     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
